// File: rtl/wb_gp_arb_if.sv
// Bus bundle for the GP write-port arbiter: WB write, two late requesters,
// regfile write port and pending-target status.
interface wb_gp_arb_if #(
  parameter int DATA_W = 24,
  parameter int TGT_W  = 4,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              iw_wb_we;
  logic [TGT_W-1:0]  iw_wb_addr;
  logic [DATA_W-1:0] iw_wb_data;

  logic              iw_req0_valid, iw_req1_valid;
  logic [TGT_W-1:0]  iw_req0_addr,  iw_req1_addr;
  logic [DATA_W-1:0] iw_req0_data,  iw_req1_data;
  logic              ow_req0_ready, ow_req1_ready;

  logic              ow_gp_write_enable;
  logic [TGT_W-1:0]  ow_gp_write_addr;
  logic [DATA_W-1:0] ow_gp_write_data;

  logic [(1<<TGT_W)-1:0] ow_pend_mask;
  logic [CNT_W-1:0]      ow_count;
  logic                  ow_full;

  modport slave (
    input  iw_wb_we, iw_wb_addr, iw_wb_data,
    input  iw_req0_valid, iw_req0_addr, iw_req0_data,
    input  iw_req1_valid, iw_req1_addr, iw_req1_data,
    output ow_req0_ready, ow_req1_ready,
    output ow_gp_write_enable, ow_gp_write_addr, ow_gp_write_data,
    output ow_pend_mask, ow_count, ow_full
  );

  modport master (
    output iw_wb_we, iw_wb_addr, iw_wb_data,
    output iw_req0_valid, iw_req0_addr, iw_req0_data,
    output iw_req1_valid, iw_req1_addr, iw_req1_data,
    input  ow_req0_ready, ow_req1_ready,
    input  ow_gp_write_enable, ow_gp_write_addr, ow_gp_write_data,
    input  ow_pend_mask, ow_count, ow_full
  );
endinterface

// File: rtl/wb_gp_arb.sv
// GP regfile write-port arbiter: WB always wins, late results are queued in a
// small FIFO (with WB-supersede kill) and drained on WB-idle cycles.

// One FIFO entry {live, addr, data}.
module wb_gp_arb_slot #(
  parameter int DATA_W = 24,
  parameter int TGT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_live,
  input  logic [TGT_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop_en,
  input  logic              kill_en,
  input  logic [TGT_W-1:0]  kill_addr,
  output logic              live,
  output logic [TGT_W-1:0]  addr,
  output logic [DATA_W-1:0] data
);
  // write and pop never hit the same slot in one cycle (wptr==rptr implies
  // empty or full), and pops only happen while WB is idle so never race a kill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (wr_en) begin
      live <= wr_live;
      addr <= wr_addr;
      data <= wr_data;
    end else if (pop_en) begin
      live <= 1'b0;
    end else if (kill_en && addr == kill_addr) begin
      live <= 1'b0;
    end
  end
endmodule

module wb_gp_arb #(
  parameter int DATA_W = 24,
  parameter int TGT_W  = 4,
  parameter int DEPTH  = 4   // power of 2, >= 2
) (
  input  logic        iw_clk,
  input  logic        iw_rst_n,
  wb_gp_arb_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NTGT  = 1 << TGT_W;

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] cnt;
  logic             r_last;

  logic                          not_full, gnt0, gnt1, push, pop, wb_en;
  logic [TGT_W-1:0]              push_addr;
  logic [DATA_W-1:0]             push_data;
  logic                          push_live;
  logic [DEPTH-1:0]              s_live;
  logic [DEPTH-1:0][TGT_W-1:0]   s_addr;
  logic [DEPTH-1:0][DATA_W-1:0]  s_data;
  logic [NTGT-1:0]               mask;

  // everything combinational is gated by reset so outputs read idle in reset
  assign wb_en    = iw_rst_n & bus.iw_wb_we;
  assign not_full = cnt < CNT_W'(DEPTH);
  assign gnt0 = iw_rst_n & not_full & bus.iw_req0_valid & (~bus.iw_req1_valid |  r_last);
  assign gnt1 = iw_rst_n & not_full & bus.iw_req1_valid & (~bus.iw_req0_valid | ~r_last);
  assign push = gnt0 | gnt1;
  assign pop  = iw_rst_n & ~bus.iw_wb_we & (cnt != '0);

  assign push_addr = gnt1 ? bus.iw_req1_addr : bus.iw_req0_addr;
  assign push_data = gnt1 ? bus.iw_req1_data : bus.iw_req0_data;
  // an entry enqueued on the same edge as a matching WB write is born dead
  assign push_live = ~(wb_en && bus.iw_wb_addr == push_addr);

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    wb_gp_arb_slot #(.DATA_W(DATA_W), .TGT_W(TGT_W)) u_slot (
      .clk      (iw_clk),
      .rst_n    (iw_rst_n),
      .wr_en    (push && wptr == PTR_W'(g)),
      .wr_live  (push_live),
      .wr_addr  (push_addr),
      .wr_data  (push_data),
      .pop_en   (pop && rptr == PTR_W'(g)),
      .kill_en  (wb_en),
      .kill_addr(bus.iw_wb_addr),
      .live     (s_live[g]),
      .addr     (s_addr[g]),
      .data     (s_data[g])
    );
  end

  always_comb begin
    bus.ow_gp_write_enable = 1'b0;
    bus.ow_gp_write_addr   = '0;
    bus.ow_gp_write_data   = '0;
    if (wb_en) begin
      bus.ow_gp_write_enable = 1'b1;
      bus.ow_gp_write_addr   = bus.iw_wb_addr;
      bus.ow_gp_write_data   = bus.iw_wb_data;
    end else if (pop) begin
      bus.ow_gp_write_enable = s_live[rptr];
      bus.ow_gp_write_addr   = s_addr[rptr];
      bus.ow_gp_write_data   = s_data[rptr];
    end
  end

  always_comb begin
    mask = '0;
    for (int k = 0; k < DEPTH; k++)
      if (s_live[k]) mask[s_addr[k]] = 1'b1;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      r_last <= 1'b1;
    end else begin
      if (push) begin
        wptr   <= wptr + PTR_W'(1);
        r_last <= gnt1;
      end
      if (pop) rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.ow_req0_ready = gnt0;
  assign bus.ow_req1_ready = gnt1;
  assign bus.ow_pend_mask  = mask;
  assign bus.ow_count      = cnt;
  assign bus.ow_full       = cnt == CNT_W'(DEPTH);
endmodule

// File: tb/tb_wb_gp_arb.sv
// Directed vector bench for wb_gp_arb (DATA_W=24, TGT_W=4, DEPTH=4).
module tb_wb_gp_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_gp_arb_if bus ();
  wb_gp_arb dut (.iw_clk(clk), .iw_rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [23:0] rf [16];

  always @(posedge clk)
    if (bus.ow_gp_write_enable) rf[bus.ow_gp_write_addr] <= bus.ow_gp_write_data;

  typedef struct {
    logic rst, we; logic [3:0] wa; logic [23:0] wd;
    logic v0; logic [3:0] a0; logic [23:0] d0;
    logic v1; logic [3:0] a1; logic [23:0] d1;
    logic r0, r1, ge; logic [3:0] ga; logic [23:0] gd;
    logic [15:0] mask; logic [2:0] cnt; logic full;
  } vec_t;

  function automatic vec_t mk(
    logic rst, logic we, logic [3:0] wa, logic [23:0] wd,
    logic v0, logic [3:0] a0, logic [23:0] d0,
    logic v1, logic [3:0] a1, logic [23:0] d1,
    logic r0, logic r1, logic ge, logic [3:0] ga, logic [23:0] gd,
    logic [15:0] mask, logic [2:0] cnt, logic full);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = wa; v.wd = wd;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.ge = ge; v.ga = ga; v.gd = gd;
    v.mask = mask; v.cnt = cnt; v.full = full;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [3:0] wa, logic [23:0] wd,
                       logic v0, logic [3:0] a0, logic [23:0] d0,
                       logic v1, logic [3:0] a1, logic [23:0] d1);
    bus.iw_wb_we = we; bus.iw_wb_addr = wa; bus.iw_wb_data = wd;
    bus.iw_req0_valid = v0; bus.iw_req0_addr = a0; bus.iw_req0_data = d0;
    bus.iw_req1_valid = v1; bus.iw_req1_addr = a1; bus.iw_req1_data = d1;
  endtask

  vec_t vt [27];

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 24'h0;
    drive(1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 24'h0);

    // reset asserted with busy inputs, then idle
    vt[0]  = mk(0,1,4'h7,24'h5,   1,4'h3,24'h1,     1,4'h2,24'h2,  0,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    vt[1]  = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    // single late write, drained next cycle
    vt[2]  = mk(1,0,4'h0,24'h0,   1,4'h3,24'h00ABCD,0,4'h0,24'h0,  1,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    vt[3]  = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,1,4'h3,24'h00ABCD,16'h0008,3'd1,0);
    vt[4]  = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    // reset so req0 wins the first tie, then round-robin fill under WB
    vt[5]  = mk(0,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    vt[6]  = mk(1,1,4'h9,24'h900, 1,4'h1,24'h11,    1,4'h2,24'h22, 1,0,1,4'h9,24'h900,   16'h0000,3'd0,0);
    vt[7]  = mk(1,1,4'h9,24'h901, 1,4'h1,24'h11,    1,4'h2,24'h22, 0,1,1,4'h9,24'h901,   16'h0002,3'd1,0);
    vt[8]  = mk(1,1,4'h9,24'h902, 1,4'h1,24'h11,    1,4'h2,24'h22, 1,0,1,4'h9,24'h902,   16'h0006,3'd2,0);
    vt[9]  = mk(1,1,4'h9,24'h903, 1,4'h1,24'h11,    1,4'h2,24'h22, 0,1,1,4'h9,24'h903,   16'h0006,3'd3,0);
    vt[10] = mk(1,1,4'h9,24'h904, 1,4'h1,24'h11,    1,4'h2,24'h22, 0,0,1,4'h9,24'h904,   16'h0006,3'd4,1);
    // drain GP1, GP2, GP1, GP2
    vt[11] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,1,4'h1,24'h11,    16'h0006,3'd4,1);
    vt[12] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,1,4'h2,24'h22,    16'h0006,3'd3,0);
    vt[13] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,1,4'h1,24'h11,    16'h0006,3'd2,0);
    vt[14] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,1,4'h2,24'h22,    16'h0004,3'd1,0);
    vt[15] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    // kill of a queued entry by a later WB write
    vt[16] = mk(1,0,4'h0,24'h0,   1,4'h5,24'h111,   0,4'h0,24'h0,  1,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    vt[17] = mk(1,1,4'h5,24'h222, 0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,1,4'h5,24'h222,   16'h0020,3'd1,0);
    vt[18] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,0,4'h5,24'h111,   16'h0000,3'd1,0);
    vt[19] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    // kill of the entry enqueued on the same edge
    vt[20] = mk(1,1,4'h6,24'h333, 0,4'h0,24'h0,     1,4'h6,24'h444,0,1,1,4'h6,24'h333,   16'h0000,3'd0,0);
    vt[21] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,0,4'h6,24'h444,   16'h0000,3'd1,0);
    vt[22] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,0,4'h0,24'h0,     16'h0000,3'd0,0);
    // fill two, then push+pop in one cycle
    vt[23] = mk(1,1,4'h0,24'h55,  1,4'h7,24'h70,    0,4'h0,24'h0,  1,0,1,4'h0,24'h55,    16'h0000,3'd0,0);
    vt[24] = mk(1,1,4'h0,24'h56,  1,4'h8,24'h80,    0,4'h0,24'h0,  1,0,1,4'h0,24'h56,    16'h0080,3'd1,0);
    vt[25] = mk(1,0,4'h0,24'h0,   0,4'h0,24'h0,     1,4'h9,24'h90, 0,1,1,4'h7,24'h70,    16'h0180,3'd2,0);
    vt[26] = mk(1,1,4'hF,24'h1,   0,4'h0,24'h0,     0,4'h0,24'h0,  0,0,1,4'hF,24'h1,     16'h0300,3'd2,0);

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst_n = vt[i].rst;
      drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].v0, vt[i].a0, vt[i].d0,
            vt[i].v1, vt[i].a1, vt[i].d1);
      #2;
      chk($sformatf("v%0d.rdy0", i), 32'(bus.ow_req0_ready),      32'(vt[i].r0));
      chk($sformatf("v%0d.rdy1", i), 32'(bus.ow_req1_ready),      32'(vt[i].r1));
      chk($sformatf("v%0d.we", i),   32'(bus.ow_gp_write_enable), 32'(vt[i].ge));
      chk($sformatf("v%0d.addr", i), 32'(bus.ow_gp_write_addr),   32'(vt[i].ga));
      chk($sformatf("v%0d.data", i), 32'(bus.ow_gp_write_data),   32'(vt[i].gd));
      chk($sformatf("v%0d.mask", i), 32'(bus.ow_pend_mask),       32'(vt[i].mask));
      chk($sformatf("v%0d.count", i),32'(bus.ow_count),           32'(vt[i].cnt));
      chk($sformatf("v%0d.full", i), 32'(bus.ow_full),            32'(vt[i].full));
    end

    // asynchronous reset pulse between edges with two entries queued
    @(negedge clk);
    drive(1'b1, 4'hF, 24'h1, 1'b1, 4'h1, 24'h11, 1'b1, 4'h2, 24'h22);
    rst_n = 1'b0;
    #2;
    chk("rst.count", 32'(bus.ow_count),           32'd0);
    chk("rst.mask",  32'(bus.ow_pend_mask),       32'd0);
    chk("rst.full",  32'(bus.ow_full),            32'd0);
    chk("rst.we",    32'(bus.ow_gp_write_enable), 32'd0);
    chk("rst.rdy",   32'({bus.ow_req1_ready, bus.ow_req0_ready}), 32'd0);
    #1 rst_n = 1'b1;
    drive(1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 24'h0);
    #1;
    chk("post_rst.we",    32'(bus.ow_gp_write_enable), 32'd0);
    chk("post_rst.count", 32'(bus.ow_count),           32'd0);
    @(negedge clk);
    chk("post_rst.idle_we", 32'(bus.ow_gp_write_enable), 32'd0);
    drive(1'b1, 4'h0, 24'h0, 1'b1, 4'h1, 24'h11, 1'b1, 4'h2, 24'h22);
    #1;
    chk("post_rst.tie", 32'({bus.ow_req1_ready, bus.ow_req0_ready}), 32'b01);
    @(negedge clk);
    drive(1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 24'h0, 1'b0, 4'h0, 24'h0);
    #1;
    chk("post_rst.head", 32'(bus.ow_gp_write_addr), 32'd1);

    chk("rf.gp3", 32'(rf[3]), 32'h00ABCD);
    chk("rf.gp5", 32'(rf[5]), 32'h000222);
    chk("rf.gp6", 32'(rf[6]), 32'h000333);
    chk("rf.gp8", 32'(rf[8]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_gp_arb.md
# wb_gp_arb

Write-port arbiter for the GP register file, placed between the writeback stage and regfile. The WB stage's GP write always wins; two long-latency requesters (e.g. multiply/divide unit, late load return) present results over valid/ready handshakes. Accepted late results are buffered in a small FIFO and drained on cycles when WB does not write. The block also exports a mask of GP targets with pending late writes, which the hazard logic uses to stall.

## Interface
- `DATA_W`, default 24: GP data width.
- `TGT_W`, default 4: GP target address width.
- `DEPTH`, default 4: late-write FIFO depth. Must be a power of 2 and at least 2.
- `iw_clk` in 1: single clock. All state updates on the rising edge.
- `iw_rst_n` in 1: reset, asynchronous and active-low.
- `iw_wb_we` in 1: WB stage GP write enable.
- `iw_wb_addr` in TGT_W: WB stage GP write target.
- `iw_wb_data` in DATA_W: WB stage GP write data.
- `iw_req0_valid`, `iw_req1_valid` in 1: late requester has a result.
- `iw_req0_addr`, `iw_req1_addr` in TGT_W: late result target.
- `iw_req0_data`, `iw_req1_data` in DATA_W: late result data.
- `ow_req0_ready`, `ow_req1_ready` out 1: result accepted at this edge when high together with valid.
- `ow_gp_write_enable` out 1: regfile write enable.
- `ow_gp_write_addr` out TGT_W: regfile write target.
- `ow_gp_write_data` out DATA_W: regfile write data.
- `ow_pend_mask` out 2^TGT_W: bit k set when a live FIFO entry targets GP k.
- `ow_count` out log2(DEPTH)+1: FIFO occupancy, including killed entries.
- `ow_full` out 1: `ow_count == DEPTH`.

## Operation
- **Write-port mux (combinational):**
  - `iw_wb_we`=1: the port carries the WB address and data.
  - `iw_wb_we`=0 and `ow_count`>0: this is a drain cycle. The FIFO head pops. The port carries the head's address and data, with enable equal to the head's live bit.
  - Otherwise enable is 0, and addr/data are 0.
- **FIFO entry:** {live, addr, data}. Write and read pointers have TGT-independent width log2(DEPTH) and wrap modulo DEPTH. `ow_count` is a registered counter.
- **Acceptance:**
  - At most one late request is accepted per cycle, and only when `ow_count` < DEPTH. Registered count only; a same-cycle pop does not free a slot.
  - Round-robin by a last-granted bit `r_last`. With both valid, the requester ≠ `r_last` is granted. With one valid, that one is granted.
  - `r_last` updates only on an accept.
  - Ready is high only for the granted requester. Ready may depend on valid; requesters must not make valid depend on ready.
- **Kill rule (WB supersedes late writes):**
  - On an edge where `iw_wb_we`=1, every FIFO entry whose addr equals `iw_wb_addr` gets live cleared.
  - The same applies to the entry being enqueued at that edge.
  - A killed entry still occupies a slot. It pops in a drain cycle with `ow_gp_write_enable`=0.
- **Simultaneous push and pop:** allowed whenever count < DEPTH. Count is unchanged and both pointers advance.
- **`ow_pend_mask`:** OR over live entries of onehot(addr). Derived from registers only, so it is valid the cycle after accept.
- **Reset (`iw_rst_n`=0, asynchronous):**
  - Pointers, count and all live bits clear; `r_last` is set to 1, so req0 wins the first tie.
  - Reset mid-operation discards all queued entries.
  - While reset is asserted: `ow_gp_write_enable`=0, both readies are 0, `ow_pend_mask`=0, `ow_count`=0, `ow_full`=0.

## Timing
- **WB write:** zero-latency, combinational pass-through to the write port. Adds no pipeline stage.
- **Late result:** accepted at edge N. Earliest regfile write is the cycle after N, if WB is idle.
- **Minimum occupancy:** one cycle.
- **Late-write starvation:** unbounded while `iw_wb_we` stays high. Requesters hold valid until ready; back-pressure is via `ow_full`.
- **Drain throughput:** one entry per WB-idle cycle.
- **Counter:** `ow_count` never exceeds DEPTH and never underflows. No pop when it is 0.

## Test plan
1. **Reset and idle.**
   - Stimulus: assert reset, release, WB idle, no requests.
   - Required: all outputs 0 and both readies 0 during reset. After release, `ow_count`=0 and `ow_pend_mask`=0.
2. **Late write only.**
   - Stimulus: req0 {addr 3, data 24'h00ABCD} for one cycle, WB idle.
   - Required: ready0=1 at accept. Next cycle `ow_pend_mask`=16'h0008 and the port writes GP3=24'h00ABCD. The cycle after, the mask is 0.
3. **Round-robin and full.**
   - Stimulus: both requesters valid continuously (addr 1 and 2), WB writing every cycle.
   - Required: accepts alternate req0, req1, req0, req1. `ow_full`=1 after 4 accepts and both readies drop. Port shows only WB writes.
   - Follow-on: drop WB. Drain order is GP1, GP2, GP1, GP2, one per cycle.
4. **Kill.**
   - Stimulus: queue {5, 24'h000111}, then WB writes GP5=24'h000222, then WB goes idle.
   - Required: the GP5 bit in the mask clears after the WB edge. The drain cycle pops with enable=0. `ow_count` goes 1 to 0. Final GP5 value is 24'h000222.
5. **Push+pop and reset mid-operation.**
   - Stimulus: WB idle, FIFO holds 2 entries, req1 valid.
   - Required: accept and drain happen in the same cycle, and count stays 2.
   - Follow-on: pulse reset low between clock edges. Count, mask and pointers clear immediately. The queued entries are never written, and req0 wins the next tie.
